hazard_stall_controller: RTL and testbench
==========================================

HAZARD_STALL_CONTROLLER -- requirements
Module: hazard_stall_controller

Interface
REQ-001 The block SHALL have one clock, clk (input, 1): all state updates on its rising edge.
REQ-002 The block SHALL have one reset, rst (input, 1): synchronous, active-high.
REQ-003 The block SHALL have inputs ID_Rs and ID_Rt (5 each): source registers of the instruction in ID.
REQ-004 The block SHALL have input ID_UsesRt (1): the ID instruction reads Rt.
REQ-005 The block SHALL have inputs ID_Branch, ID_BranchTaken and ID_Jump (1 each): ID branch, ID comparator outcome, and ID jump.
REQ-006 The block SHALL have inputs ID_Ex_MemRead and ID_Ex_RegWrite (1 each), and ID_Ex_WriteReg (5).
REQ-007 The block SHALL have inputs Ex_Mem_MemRead (1) and Ex_Mem_WriteReg (5).
REQ-008 The block SHALL have input MemBusy (1): data memory not ready.
REQ-009 The block SHALL have outputs PCWrite and IF_ID_Write (1 each): enables for the PC and IF/ID registers.
REQ-010 The block SHALL have output ID_Ex_Bubble (1): zeroes the ID/EX control fields.
REQ-011 The block SHALL have output IF_ID_Flush (1): clears the IF/ID instruction.
REQ-012 The block SHALL have output PipeHold (1): freezes ID/EX, EX/MEM and MEM/WB.
REQ-013 The block SHALL have output StallCycles (16): saturating count of bubble cycles.

Function
REQ-014 A register SHALL match only when it is nonzero and equal; an Rt match additionally requires ID_UsesRt=1.
REQ-015 Required stall count N SHALL be the maximum applicable value from these rules:
- Load-use (ID_Ex_MemRead with Rs/Rt match): N=1.
- Branch-on-ALU-result (ID_Branch with ID_Ex_RegWrite, !ID_Ex_MemRead and a match): N=1.
- Branch-on-load in EX (ID_Branch with ID_Ex_MemRead and a match): N=2.
- Branch-on-load in MEM (ID_Branch with Ex_Mem_MemRead and an Ex_Mem_WriteReg match): N=1.
- Otherwise: N=0.
REQ-016 The FSM SHALL have states RUN, STALL and FREEZE, plus a 2-bit counter cnt.
REQ-017 In RUN with N>0, the block SHALL in the same cycle drive PCWrite=0, IF_ID_Write=0 and ID_Ex_Bubble=1.
- Next state: STALL with cnt=N-1 if N=2, else remain in RUN.
REQ-018 In STALL, the block SHALL assert the stall outputs and decrement cnt without re-evaluating hazards, returning to RUN when cnt reaches 0.
- Branch-after-load therefore totals exactly 2 bubble cycles.
REQ-019 In RUN with N=0, the block SHALL assert IF_ID_Flush=1 for one cycle when ID_Jump=1 or (ID_Branch and ID_BranchTaken); PCWrite=1 and IF_ID_Write=1.
REQ-020 IF_ID_Flush SHALL never be asserted in the same cycle as ID_Ex_Bubble or PipeHold.
REQ-021 MemBusy=1 SHALL have priority over all other conditions in any state:
- Outputs: PipeHold=1, PCWrite=0, IF_ID_Write=0, ID_Ex_Bubble=0, IF_ID_Flush=0.
- Next state: FREEZE; cnt and the prior state are retained.
REQ-022 When MemBusy falls, FREEZE SHALL return to the retained state (RUN or STALL with the held cnt), and outputs SHALL be evaluated normally in that cycle.
REQ-023 StallCycles SHALL increment on every cycle with ID_Ex_Bubble=1 and saturate at 16'hFFFF.
REQ-024 Outputs SHALL be combinational decodes of state, cnt and inputs, with zero-cycle latency from hazard detection.

Reset
REQ-025 While rst=1 at a clock edge, the next state SHALL be RUN with cnt=0, the retained state RUN and StallCycles=0.
REQ-026 During a cycle with rst=1, the outputs SHALL be PCWrite=1, IF_ID_Write=1 and all other 1-bit outputs 0, regardless of the other inputs.
REQ-027 Reset asserted mid-STALL or mid-FREEZE SHALL abandon the remaining stall cycles.

Structure
REQ-028 The state encoding (RUN=2'd0, STALL=2'd1, FREEZE=2'd2) and the 5-bit register index width SHALL live in the shared pipeline package.
REQ-029 Hazard detection (REQ-014/015) SHALL be a combinational sub-module, hazard_detect, outputting N; the FSM, counters and output decode SHALL stay in the top module.

Verification
REQ-030 Load-use: ID_Ex_MemRead=1, ID_Ex_WriteReg=5, ID_Rs=5 -> one cycle of PCWrite=0 and ID_Ex_Bubble=1, then RUN; StallCycles=1.
REQ-031 Branch-after-load: ID_Branch=1, ID_Ex_MemRead=1, WriteReg=8, ID_Rt=8, ID_UsesRt=1 -> exactly 2 bubble cycles, then IF_ID_Flush=1 if ID_BranchTaken=1.
REQ-032 $zero: ID_Ex_MemRead=1, WriteReg=0, ID_Rs=0 -> no stall.
REQ-033 MemBusy held 3 cycles during STALL with cnt=1 -> PipeHold=1 for 3 cycles, no bubble; then 1 bubble cycle, then RUN.
REQ-034 Saturation: StallCycles preset near 16'hFFFF via 65535 forced stalls -> remains 16'hFFFF on the next bubble.
REQ-035 rst=1 during STALL -> next cycle RUN, PCWrite=1, StallCycles=0.

Source files
------------

// File: rtl/hazard_stall_controller_pkg.sv
// Shared pipeline definitions for the hazard/stall controller.
// Holds the register-index width, the controller state encoding and the
// register-match helper used by hazard detection.
package hazard_stall_controller_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_FREEZE = 2'd2
  } state_t;

  // A producer/consumer pair only conflicts on a real register: $zero never matches.
  function automatic logic reg_match(input logic [REG_W-1:0] a,
                                     input logic [REG_W-1:0] b);
    return (a != {REG_W{1'b0}}) && (a == b);
  endfunction

endpackage

// File: rtl/hazard_stall_controller_hazard_detect.sv
// Combinational hazard detection.
// Compares the ID source registers against the destinations of the
// instructions in EX and MEM and reports the number of bubble cycles (n)
// needed before the ID instruction may proceed.
// Ports:
//   id_rs, id_rt            source registers of the ID instruction
//   id_uses_rt              ID instruction actually reads rt
//   id_branch               ID instruction is a branch resolved in ID
//   id_ex_mem_read          EX instruction is a load
//   id_ex_reg_write         EX instruction writes a register
//   id_ex_write_reg         EX destination register
//   ex_mem_mem_read         MEM instruction is a load
//   ex_mem_write_reg        MEM destination register
//   n                       required stall count (0..2)
module hazard_detect
  import hazard_stall_controller_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_branch,
  input  logic             id_ex_mem_read,
  input  logic             id_ex_reg_write,
  input  logic [REG_W-1:0] id_ex_write_reg,
  input  logic             ex_mem_mem_read,
  input  logic [REG_W-1:0] ex_mem_write_reg,
  output logic [1:0]       n
);

  logic ex_hit;
  logic mem_hit;

  // Source-register matches against the EX and MEM destinations.
  always_comb begin
    ex_hit  = reg_match(id_rs, id_ex_write_reg) ||
              (id_uses_rt && reg_match(id_rt, id_ex_write_reg));
    mem_hit = reg_match(id_rs, ex_mem_write_reg) ||
              (id_uses_rt && reg_match(id_rt, ex_mem_write_reg));
  end

  // Take the largest stall demanded by any applicable rule.
  always_comb begin
    n = 2'd0;
    if (id_branch && id_ex_mem_read && ex_hit) begin
      // Load data reaches the ID comparator only after EX and MEM.
      n = 2'd2;
    end else if (id_ex_mem_read && ex_hit) begin
      n = 2'd1;
    end else if (id_branch && id_ex_reg_write && !id_ex_mem_read && ex_hit) begin
      n = 2'd1;
    end else if (id_branch && ex_mem_mem_read && mem_hit) begin
      n = 2'd1;
    end else begin
      n = 2'd0;
    end
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard/stall controller.
// Inserts bubbles for load-use and branch-operand hazards, flushes IF/ID on
// taken branches and jumps, and freezes the back end while data memory is
// busy. All control outputs are same-cycle decodes of state and inputs.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   ID_Rs, ID_Rt, ID_UsesRt          ID instruction sources
//   ID_Branch, ID_BranchTaken, ID_Jump  ID control-flow information
//   ID_Ex_MemRead, ID_Ex_RegWrite, ID_Ex_WriteReg  EX instruction info
//   Ex_Mem_MemRead, Ex_Mem_WriteReg  MEM instruction info
//   MemBusy                          data memory not ready
//   PCWrite, IF_ID_Write             front-end enables
//   ID_Ex_Bubble                     zero ID/EX control fields
//   IF_ID_Flush                      squash the IF/ID instruction
//   PipeHold                         freeze ID/EX, EX/MEM, MEM/WB
//   StallCycles                      saturating bubble-cycle count
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] ID_Rs,
  input  logic [REG_W-1:0] ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             ID_Branch,
  input  logic             ID_BranchTaken,
  input  logic             ID_Jump,
  input  logic             ID_Ex_MemRead,
  input  logic             ID_Ex_RegWrite,
  input  logic [REG_W-1:0] ID_Ex_WriteReg,
  input  logic             Ex_Mem_MemRead,
  input  logic [REG_W-1:0] Ex_Mem_WriteReg,
  input  logic             MemBusy,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             ID_Ex_Bubble,
  output logic             IF_ID_Flush,
  output logic             PipeHold,
  output logic [15:0]      StallCycles
);

  logic [1:0]  n;
  state_t      state;
  state_t      ret_state;
  state_t      eff_state;
  state_t      next_state;
  state_t      next_ret;
  logic [1:0]  cnt;
  logic [1:0]  next_cnt;
  logic [15:0] stall_count;

  hazard_detect u_hazard_detect (
    .id_rs            (ID_Rs),
    .id_rt            (ID_Rt),
    .id_uses_rt       (ID_UsesRt),
    .id_branch        (ID_Branch),
    .id_ex_mem_read   (ID_Ex_MemRead),
    .id_ex_reg_write  (ID_Ex_RegWrite),
    .id_ex_write_reg  (ID_Ex_WriteReg),
    .ex_mem_mem_read  (Ex_Mem_MemRead),
    .ex_mem_write_reg (Ex_Mem_WriteReg),
    .n                (n)
  );

  // In FREEZE the retained state is what gets evaluated once MemBusy drops,
  // so the release cycle behaves exactly like the state it interrupted.
  always_comb begin
    if (state == ST_FREEZE) begin
      eff_state = ret_state;
    end else begin
      eff_state = state;
    end
  end

  // Next-state and output decode.
  always_comb begin
    next_state   = eff_state;
    next_ret     = ret_state;
    next_cnt     = cnt;
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_Ex_Bubble = 1'b0;
    IF_ID_Flush  = 1'b0;
    PipeHold     = 1'b0;
    if (rst) begin
      next_state = ST_RUN;
      next_ret   = ST_RUN;
      next_cnt   = 2'd0;
    end else if (MemBusy) begin
      // Memory stall dominates; cnt and the interrupted state are kept.
      PipeHold    = 1'b1;
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      next_state  = ST_FREEZE;
      next_ret    = eff_state;
    end else begin
      case (eff_state)
        ST_RUN: begin
          if (n != 2'd0) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_Ex_Bubble = 1'b1;
            if (n == 2'd2) begin
              next_state = ST_STALL;
              next_cnt   = n - 2'd1;
            end else begin
              next_state = ST_RUN;
              next_cnt   = 2'd0;
            end
          end else begin
            next_state = ST_RUN;
            if (ID_Jump || (ID_Branch && ID_BranchTaken)) begin
              IF_ID_Flush = 1'b1;
            end else begin
              IF_ID_Flush = 1'b0;
            end
          end
        end
        ST_STALL: begin
          // Hazards are not re-evaluated while counting down.
          PCWrite      = 1'b0;
          IF_ID_Write  = 1'b0;
          ID_Ex_Bubble = 1'b1;
          if (cnt <= 2'd1) begin
            next_state = ST_RUN;
            next_cnt   = 2'd0;
          end else begin
            next_state = ST_STALL;
            next_cnt   = cnt - 2'd1;
          end
        end
        default: begin
          next_state = ST_RUN;
          next_cnt   = 2'd0;
        end
      endcase
    end
  end

  // State, counter and bubble-statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      ret_state   <= ST_RUN;
      cnt         <= 2'd0;
      stall_count <= 16'd0;
    end else begin
      state     <= next_state;
      ret_state <= next_ret;
      cnt       <= next_cnt;
      if (ID_Ex_Bubble && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end else begin
        stall_count <= stall_count;
      end
    end
  end

  assign StallCycles = stall_count;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed self-checking bench for hazard_stall_controller.
// Output vector order in checks: {PCWrite, IF_ID_Write, ID_Ex_Bubble, IF_ID_Flush, PipeHold}.
module tb_hazard_stall_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ID_Rs, ID_Rt;
  logic        ID_UsesRt, ID_Branch, ID_BranchTaken, ID_Jump;
  logic        ID_Ex_MemRead, ID_Ex_RegWrite;
  logic [4:0]  ID_Ex_WriteReg;
  logic        Ex_Mem_MemRead;
  logic [4:0]  Ex_Mem_WriteReg;
  logic        MemBusy;
  logic        PCWrite, IF_ID_Write, ID_Ex_Bubble, IF_ID_Flush, PipeHold;
  logic [15:0] StallCycles;

  int checks = 0;
  int failures = 0;

  hazard_stall_controller dut (
    .clk             (clk),
    .rst             (rst),
    .ID_Rs           (ID_Rs),
    .ID_Rt           (ID_Rt),
    .ID_UsesRt       (ID_UsesRt),
    .ID_Branch       (ID_Branch),
    .ID_BranchTaken  (ID_BranchTaken),
    .ID_Jump         (ID_Jump),
    .ID_Ex_MemRead   (ID_Ex_MemRead),
    .ID_Ex_RegWrite  (ID_Ex_RegWrite),
    .ID_Ex_WriteReg  (ID_Ex_WriteReg),
    .Ex_Mem_MemRead  (Ex_Mem_MemRead),
    .Ex_Mem_WriteReg (Ex_Mem_WriteReg),
    .MemBusy         (MemBusy),
    .PCWrite         (PCWrite),
    .IF_ID_Write     (IF_ID_Write),
    .ID_Ex_Bubble    (ID_Ex_Bubble),
    .IF_ID_Flush     (IF_ID_Flush),
    .PipeHold        (PipeHold),
    .StallCycles     (StallCycles)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are changed 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rst = 1'b0; ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRt = 1'b0;
    ID_Branch = 1'b0; ID_BranchTaken = 1'b0; ID_Jump = 1'b0;
    ID_Ex_MemRead = 1'b0; ID_Ex_RegWrite = 1'b0; ID_Ex_WriteReg = 5'd0;
    Ex_Mem_MemRead = 1'b0; Ex_Mem_WriteReg = 5'd0; MemBusy = 1'b0;
  endtask

  // Settle combinational outputs, then compare the 5 control outputs.
  task automatic chk_outs(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    #1;
    obs = {PCWrite, IF_ID_Write, ID_Ex_Bubble, IF_ID_Flush, PipeHold};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] exp);
    #1;
    checks++;
    assert (StallCycles === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, StallCycles, exp);
    end
  endtask

  localparam logic [4:0] O_RUN   = 5'b11000;
  localparam logic [4:0] O_BUB   = 5'b00100;
  localparam logic [4:0] O_FLUSH = 5'b11010;
  localparam logic [4:0] O_HOLD  = 5'b00001;

  initial begin
    clr();
    // Reset overrides every other input.
    rst = 1'b1; MemBusy = 1'b1; ID_Jump = 1'b1;
    ID_Ex_MemRead = 1'b1; ID_Ex_WriteReg = 5'd5; ID_Rs = 5'd5;
    chk_outs("reset_outputs", O_RUN);
    tick();
    tick();
    clr();
    chk_outs("idle_after_reset", O_RUN);
    chk_cnt("count_after_reset", 16'd0);

    // Load-use on Rs.
    ID_Ex_MemRead = 1'b1; ID_Ex_WriteReg = 5'd5; ID_Rs = 5'd5;
    chk_outs("load_use_bubble", O_BUB);
    tick();
    clr();
    chk_outs("load_use_release", O_RUN);
    chk_cnt("load_use_count", 16'd1);

    // $zero never matches.
    ID_Ex_MemRead = 1'b1; ID_Ex_WriteReg = 5'd0; ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRt = 1'b1;
    chk_outs("zero_reg_no_stall", O_RUN);
    tick();

    // Rt match needs UsesRt.
    clr();
    ID_Ex_MemRead = 1'b1; ID_Ex_WriteReg = 5'd7; ID_Rt = 5'd7; ID_UsesRt = 1'b0;
    chk_outs("rt_unused_no_stall", O_RUN);
    ID_UsesRt = 1'b1;
    chk_outs("rt_used_stall", O_BUB);
    tick();

    // Branch on ALU result in EX: one bubble.
    clr();
    ID_Branch = 1'b1; ID_Ex_RegWrite = 1'b1; ID_Ex_WriteReg = 5'd9; ID_Rs = 5'd9;
    chk_outs("branch_alu_bubble", O_BUB);
    tick();
    clr();
    chk_cnt("branch_alu_count", 16'd3);

    // Branch after load: two bubbles, then taken-branch flush.
    ID_Branch = 1'b1; ID_BranchTaken = 1'b1; ID_Ex_MemRead = 1'b1;
    ID_Ex_WriteReg = 5'd8; ID_Rt = 5'd8; ID_UsesRt = 1'b1;
    chk_outs("branch_load_bubble1", O_BUB);
    tick();
    ID_Ex_MemRead = 1'b0; Ex_Mem_MemRead = 1'b1; Ex_Mem_WriteReg = 5'd8;
    chk_outs("branch_load_bubble2", O_BUB);
    tick();
    Ex_Mem_MemRead = 1'b0;
    chk_outs("branch_load_flush", O_FLUSH);
    chk_cnt("branch_load_count", 16'd5);
    tick();

    // Branch on load in MEM: one bubble; then untaken branch, then jump.
    clr();
    ID_Branch = 1'b1; Ex_Mem_MemRead = 1'b1; Ex_Mem_WriteReg = 5'd4; ID_Rs = 5'd4;
    chk_outs("branch_mem_load_bubble", O_BUB);
    tick();
    Ex_Mem_MemRead = 1'b0;
    chk_outs("branch_not_taken", O_RUN);
    tick();
    clr();
    ID_Jump = 1'b1;
    chk_outs("jump_flush", O_FLUSH);
    tick();
    clr();
    chk_cnt("count_before_freeze", 16'd6);

    // MemBusy during STALL with cnt=1: 3 hold cycles, then one bubble.
    ID_Branch = 1'b1; ID_Ex_MemRead = 1'b1; ID_Ex_WriteReg = 5'd3; ID_Rs = 5'd3;
    chk_outs("freeze_setup_bubble", O_BUB);
    tick();
    clr();
    MemBusy = 1'b1; ID_Jump = 1'b1;
    chk_outs("freeze_hold1", O_HOLD);
    tick();
    chk_outs("freeze_hold2", O_HOLD);
    tick();
    chk_outs("freeze_hold3", O_HOLD);
    tick();
    chk_cnt("freeze_no_count", 16'd7);
    clr();
    chk_outs("freeze_release_bubble", O_BUB);
    tick();
    chk_outs("freeze_back_to_run", O_RUN);
    chk_cnt("freeze_count", 16'd8);

    // MemBusy in RUN with a pending load-use, then evaluated on release.
    ID_Ex_MemRead = 1'b1; ID_Ex_WriteReg = 5'd6; ID_Rs = 5'd6; MemBusy = 1'b1;
    chk_outs("run_freeze_hold", O_HOLD);
    tick();
    MemBusy = 1'b0;
    chk_outs("run_freeze_release", O_BUB);
    tick();
    clr();
    chk_cnt("run_freeze_count", 16'd9);

    // Reset during STALL abandons the remaining bubble.
    ID_Branch = 1'b1; ID_Ex_MemRead = 1'b1; ID_Ex_WriteReg = 5'd2; ID_Rs = 5'd2;
    tick();
    clr();
    rst = 1'b1;
    chk_outs("reset_in_stall_outputs", O_RUN);
    tick();
    clr();
    chk_outs("after_reset_stall_run", O_RUN);
    chk_cnt("after_reset_stall_count", 16'd0);

    // Reset during FREEZE clears the retained STALL state.
    ID_Branch = 1'b1; ID_Ex_MemRead = 1'b1; ID_Ex_WriteReg = 5'd2; ID_Rs = 5'd2;
    tick();
    clr();
    MemBusy = 1'b1;
    tick();
    rst = 1'b1;
    chk_outs("reset_in_freeze_outputs", O_RUN);
    tick();
    clr();
    chk_outs("after_reset_freeze_run", O_RUN);

    // Saturation: continuous load-use bubbles from a count of zero.
    chk_cnt("sat_start", 16'd0);
    ID_Ex_MemRead = 1'b1; ID_Ex_WriteReg = 5'd5; ID_Rs = 5'd5;
    for (int i = 0; i < 65534; i++) begin
      tick();
    end
    chk_cnt("sat_fffe", 16'hFFFE);
    tick();
    chk_cnt("sat_ffff", 16'hFFFF);
    chk_outs("sat_still_bubble", O_BUB);
    tick();
    chk_cnt("sat_hold", 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
